// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: holds Address READ_CYCLES cycles, then captures Data into a DEPTH-entry prefetch queue.
// One instruction per READ_CYCLES cycles; decode backpressure stalls capture with Address held, Redirect flushes.
module instr_fetch_unit #(
  parameter int READ_CYCLES = 2,
  parameter int DEPTH       = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [63:0] StartPC,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  input  logic        Halt,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    LAST = 4'(READ_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [63:0]   pc_mem_q   [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];
  logic          pop, push, cap_due;

  assign InstrValid = (occ_q != '0);
  assign pop        = InstrValid && InstrReady;
  assign cap_due    = !Halt && (cnt_q == LAST);
  // A full queue still accepts a capture when the head leaves on the same edge.
  assign push       = cap_due && ((occ_q != FULL) || pop);

  assign Address = pc_q;
  assign Instr   = InstrValid ? word_mem_q[rd_ptr_q] : '0;
  assign InstrPC = InstrValid ? pc_mem_q[rd_ptr_q]   : '0;

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (Redirect) begin
      pc_d     = RedirectPC & ~64'h3;
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (!Halt) begin
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else if (push) begin
          pc_d  = pc_q + 64'd4;
          cnt_d = '0;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q     <= StartPC & ~64'h3;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage needs no reset: occupancy gates every read.
  always_ff @(posedge Clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      word_mem_q[wr_ptr_q] <= Data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit: directed timing checks, then randomized ready/halt/redirect/reset.
module tb_instr_fetch_unit;
  localparam int RC = 2;
  localparam int DP = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] StartPC = '0;
  logic [63:0] Address;
  logic [31:0] Data = '0;
  logic        Halt = 1'b0;
  logic        Redirect = 1'b0;
  logic [63:0] RedirectPC = '0;
  logic        InstrValid;
  logic        InstrReady = 1'b1;
  logic [31:0] Instr;
  logic [63:0] InstrPC;

  int vectors = 0;
  int miscompares = 0;
  int handshakes = 0;
  logic [95:0] sb[$];
  logic [63:0] next_pc = '0;

  instr_fetch_unit #(.READ_CYCLES(RC), .DEPTH(DP)) dut (
    .Clk(Clk), .Reset(Reset), .StartPC(StartPC), .Address(Address), .Data(Data),
    .Halt(Halt), .Redirect(Redirect), .RedirectPC(RedirectPC), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84003E9;
      64'h4:   return 32'hF84083EA;
      64'h8:   return 32'hF84103EB;
      default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1234_5678;
    endcase
  endfunction

  // Memory model: returns the true word only once Address has been stable long enough.
  logic [63:0] prev_addr = '1;
  int age = 0;
  always @(posedge Clk) begin
    #1;
    if (Address !== prev_addr) begin
      prev_addr = Address;
      age = 0;
    end else if (age < 1000) begin
      age++;
    end
    Data = (age >= RC - 1) ? mem_word(Address) : ~mem_word(Address);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (sb.size() < 8) begin
      sb.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 64'd4;
    end
  endtask

  task automatic restart(input logic [63:0] pc);
    sb.delete();
    next_pc = pc & ~64'h3;
    topup();
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    topup();
  endtask

  always @(negedge Clk) begin
    logic [95:0] e;
    if (!Reset) begin
      if (!InstrValid) begin
        chk("idle_instr", {32'b0, Instr}, 64'd0);
        chk("idle_pc", InstrPC, 64'd0);
      end else if (InstrReady) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_empty: got pc %h with nothing expected", InstrPC);
        end else begin
          e = sb.pop_front();
          chk("pop_pc", InstrPC, e[95:32]);
          chk("pop_instr", {32'b0, Instr}, {32'b0, e[31:0]});
          handshakes++;
        end
      end
    end
  end

  initial begin
    // Basic stream from StartPC=0
    Reset = 1'b1; StartPC = 64'h0; InstrReady = 1'b1;
    tick();
    Reset = 1'b0;
    restart(64'h0);
    chk("rst_addr", Address, 64'h0);
    chk("rst_valid", {63'b0, InstrValid}, 64'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("stream_valid", {63'b0, InstrValid}, (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    chk("stream_addr", Address, 64'hC);

    // Reset with queue non-empty, unaligned StartPC, then backpressure
    Reset = 1'b1; StartPC = 64'h3; InstrReady = 1'b0;
    tick();
    Reset = 1'b0;
    restart(64'h0);
    chk("rst2_valid", {63'b0, InstrValid}, 64'd0);
    chk("rst2_instr", {32'b0, Instr}, 64'd0);
    chk("rst2_pc", InstrPC, 64'd0);
    chk("rst2_addr", Address, 64'h0);
    for (int k = 1; k <= 10; k++) tick();
    chk("bp_addr", Address, 64'h8);
    chk("bp_valid", {63'b0, InstrValid}, 64'd1);
    chk("bp_head_pc", InstrPC, 64'h0);
    InstrReady = 1'b1;
    tick();
    chk("bp_resume_addr", Address, 64'hC);
    chk("bp_resume_pc", InstrPC, 64'h4);
    tick();
    tick();

    // Redirect with full queue
    InstrReady = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("full_addr", Address, 64'h14);
    Redirect = 1'b1; RedirectPC = 64'h1F;
    tick();
    Redirect = 1'b0;
    restart(64'h1C);
    chk("redir_valid", {63'b0, InstrValid}, 64'd0);
    chk("redir_addr", Address, 64'h1C);
    tick();
    chk("redir_wait", {63'b0, InstrValid}, 64'd0);
    tick();
    chk("redir_first_valid", {63'b0, InstrValid}, 64'd1);
    chk("redir_first_pc", InstrPC, 64'h1C);
    chk("redir_first_instr", {32'b0, Instr}, {32'b0, mem_word(64'h1C)});
    tick();

    // Redirect coinciding with a pop and a due capture
    InstrReady = 1'b1; Redirect = 1'b1; RedirectPC = 64'h100;
    tick();
    Redirect = 1'b0; InstrReady = 1'b0;
    restart(64'h100);
    chk("rp_valid", {63'b0, InstrValid}, 64'd0);
    chk("rp_addr", Address, 64'h100);

    // Halt with counter mid-wait while the queue drains
    for (int k = 0; k < 4; k++) tick();
    chk("pre_halt_addr", Address, 64'h108);
    Halt = 1'b1; InstrReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_addr", Address, 64'h108);
    end
    chk("halt_drained", {63'b0, InstrValid}, 64'd0);
    Halt = 1'b0;
    tick();
    chk("resume_wait", {63'b0, InstrValid}, 64'd0);
    tick();
    chk("resume_valid", {63'b0, InstrValid}, 64'd1);
    chk("resume_pc", InstrPC, 64'h108);

    // Address wrap
    Reset = 1'b1; StartPC = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    Reset = 1'b0;
    restart(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr0", Address, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    chk("wrap_addr1", Address, 64'h0);
    chk("wrap_pc", InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic
    handshakes = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic do_rst, do_red;
      r = $urandom_range(0, 99);
      do_rst = (r == 0);
      do_red = (r >= 1 && r <= 3);
      InstrReady = ($urandom_range(0, 9) < 7);
      Halt = ($urandom_range(0, 9) == 0);
      StartPC = {$urandom, $urandom};
      RedirectPC = {$urandom, $urandom};
      Reset = do_rst;
      Redirect = do_red;
      tick();
      if (do_rst) restart(StartPC);
      else if (do_red) restart(RedirectPC);
      Reset = 1'b0;
      Redirect = 1'b0;
    end
    chk("random_progress", {63'b0, handshakes > 300}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch sequencer that drives the address port of the combinational, read-only instruction memory and buffers its output for the decode stage. It holds each fetch address stable for a programmable number of cycles to cover the memory read delay, then captures the word into a small prefetch queue. It handles decode backpressure, redirects from branch resolution and a halt request. It sits between the instruction memory and the processor's decode/control logic, replacing direct PC-to-memory wiring.

## Interface
Parameters:
- READ_CYCLES, 2, cycles Address is held stable before Data is sampled (legal range 1..15)
- DEPTH, 2, prefetch queue entries (power of two, ≥2)

Ports:
- Clk  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on Clk rising edge
- StartPC  in  64  PC loaded while Reset is high
- Address  out  64  fetch address to instruction memory (registered)
- Data  in  32  instruction word from instruction memory
- Halt  in  1  when high, no new fetch completes; queue still drains
- Redirect  in  1  flush and restart fetch at RedirectPC
- RedirectPC  in  64  new fetch PC
- InstrValid  out  1  queue head valid
- InstrReady  in  1  decode accepts head when InstrValid & InstrReady
- Instr  out  32  head instruction word
- InstrPC  out  64  PC of head instruction

## Operation
- State: fetch PC register (drives Address), wait counter 0..READ_CYCLES-1, DEPTH-entry FIFO of {PC, word}, occupancy count 0..DEPTH.
- Reset (cycle with Reset=1): fetch PC ← {StartPC[63:2],2'b00}, counter ← 0, FIFO emptied. Outputs after that edge: Address = aligned StartPC, InstrValid=0, Instr=0, InstrPC=0.
- Wait: counter increments each cycle while Halt=0 and counter < READ_CYCLES-1.
- Capture: when counter == READ_CYCLES-1, Halt=0, and (occupancy < DEPTH or a pop occurs this cycle), push {fetch PC, Data}; fetch PC ← fetch PC + 4 (mod 2^64); counter ← 0.
- Full hold: capture condition true but queue full and no pop → counter stays at READ_CYCLES-1, Address unchanged; capture retries every cycle.
- Halt: counter and fetch PC frozen; pops continue.
- Pop: InstrValid & InstrReady advances head. Simultaneous push and pop allowed at any occupancy; occupancy unchanged.
- Redirect (highest priority after Reset): FIFO emptied, any same-cycle push discarded, fetch PC ← {RedirectPC[63:2],2'b00}, counter ← 0. A same-cycle pop is still consumed by decode but has no further effect.
- Instr/InstrPC: combinational from the head FIFO entry; hold 0 when empty.
- Priority: Reset > Redirect > Halt > capture/pop.

## Timing
- Steady state, no backpressure: one instruction per READ_CYCLES cycles.
- First InstrValid: rises after the READ_CYCLES-th rising edge following the Reset-low edge. Example: READ_CYCLES=2 → valid after the 2nd edge.
- After Redirect at edge N: InstrValid=0 after N. First new instruction is valid after edge N+READ_CYCLES.
- Address changes only on a capture, Redirect or Reset edge. It is stable for at least READ_CYCLES cycles before each capture.
- Reset asserted mid-wait or with a full queue: all state is reinitialised at that edge, with no partial capture.

## Test plan
- Basic stream: READ_CYCLES=2, StartPC=0, memory words 0x000→F84003E9, 0x004→F84083EA, 0x008→F84103EB. InstrReady=1 → (PC, Instr) = (0,F84003E9), (4,F84083EA), (8,F84103EB), with InstrValid pulses every 2 cycles.
- Backpressure: InstrReady=0 for 10 cycles → queue fills to DEPTH. Address freezes at 0x008 with DEPTH=2. When Ready returns, entries pop in order with no loss or duplicate, and the fetch at 0x008 completes on the same edge as the first pop.
- Redirect with full queue: Redirect=1, RedirectPC=0x01F (unaligned) → InstrValid=0 next cycle, Address=0x01C. After READ_CYCLES edges, head = (0x1C, word at 0x1C).
- Redirect and pop in the same cycle, with a capture due → head popped, captured word discarded, queue empty, Address=RedirectPC.
- Halt for 5 cycles mid-wait: counter and Address are frozen while queued entries still drain. The fetch resumes with the counter value it had when Halt rose.
- Wrap and reset: StartPC=0xFFFFFFFFFFFFFFFC → second Address = 0x0. Assert Reset with the queue non-empty → InstrValid=0, Instr=0, InstrPC=0, Address=aligned StartPC after that edge.
